// File: rtl/pic_isr_param_pkg.sv
// Shared constants and rotating-priority helper for the parametrised 8259A ISR.
// OCW2 command encodings, the largest supported level count, and the rank search.
package pic_isr_pkg;

  localparam int MAX_IRQ   = 32;
  localparam int MAX_IDX_W = 5;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } prioRes_t;

  // Walk from the lowest rank up so the last hit is the highest-ranked bit.
  function automatic prioRes_t rotHighest(
    input logic [MAX_IRQ-1:0]   vec,
    input logic [MAX_IDX_W-1:0] lowest,
    input int                   n
  );
    prioRes_t r;
    int       j;
    r = '0;
    for (int k = MAX_IRQ; k >= 1; k--) begin
      if (k <= n) begin
        j = int'(lowest) + k;
        if (j >= n) j = j - n;
        if (vec[j[4:0]]) begin
          r.found = 1'b1;
          r.idx   = j[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_isr_param_resolver.sv
// Rotating-priority resolver: highest-ranked set bit of a level vector.
// Rank order is lowestPrio+1 (highest) around to lowestPrio (lowest).
module pic_rot_priority_resolver
  import pic_isr_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W  = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] reqVec,
  input  logic [IDX_W-1:0]   lowestPrio,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  prioRes_t res;

  assign res   = rotHighest(MAX_IRQ'(reqVec), MAX_IDX_W'(lowestPrio), NUM_IRQ);
  assign found = res.found;
  assign idx   = IDX_W'(res.idx);

endmodule

// File: rtl/pic_isr_param.sv
// Parametrised 8259A in-service register: INTA handshake, OCW2 EOI/rotate, INT.
// Define PIC_ISR_ROTATION_EN to enable rotation and set-priority commands.
module pic_isr_param
  import pic_isr_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W  = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               inta_first,
  input  logic               inta_second,
  input  logic [7:0]         vector_base,
  input  logic               aeoi_en,
  input  logic               ocw2_valid,
  input  logic [2:0]         ocw2_cmd,
  input  logic [IDX_W-1:0]   ocw2_level,
  output logic [NUM_IRQ-1:0] isr_value,
  output logic               int_out,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic               spurious,
  output logic               cleared_valid,
  output logic [IDX_W-1:0]   cleared_idx,
  output logic [IDX_W-1:0]   lowest_prio
);

`ifdef PIC_ISR_ROTATION_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LOW_RST = IDX_W'(NUM_IRQ - 1);

  logic [NUM_IRQ-1:0] isrQ, isrNext;
  logic [IDX_W-1:0]   lowQ, lowNext;
  logic [IDX_W-1:0]   servQ, servNext;
  logic [IDX_W-1:0]   clrIdxQ, clrIdxNext;
  logic               clrValidQ, clrValidNext;
  logic               rotAeoiQ, rotAeoiNext;
  logic               armedQ, armedNext;
  logic               spurQ, spurNext;
  logic [7:0]         vecQ, vecNext;
  logic               vecValidQ, vecValidNext;
  logic               intQ, intNext;

  logic               irqFound, isrFound;
  logic [IDX_W-1:0]   irqIdx, isrIdx;
  logic [IDX_W-1:0]   irqRank, isrRank;
  logic [IDX_W-1:0]   setIdx;
  prioRes_t           setRes;
  logic               unusedBase;

  assign unusedBase = ^vector_base[IDX_W-1:0];

  pic_rot_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_irqRes (
    .reqVec     (irq_req),
    .lowestPrio (lowQ),
    .found      (irqFound),
    .idx        (irqIdx)
  );

  pic_rot_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isrRes (
    .reqVec     (isrQ),
    .lowestPrio (lowQ),
    .found      (isrFound),
    .idx        (isrIdx)
  );

  // Rank 0 is the highest priority; wraps naturally at power-of-two sizes.
  assign irqRank = irqIdx - lowQ - IDX_W'(1);
  assign isrRank = isrIdx - lowQ - IDX_W'(1);
  assign intNext = irqFound && (!isrFound || (irqRank < isrRank));

  always_comb begin
    isrNext      = isrQ;
    lowNext      = lowQ;
    rotAeoiNext  = rotAeoiQ;
    servNext     = servQ;
    armedNext    = armedQ;
    spurNext     = spurQ;
    clrValidNext = 1'b0;
    clrIdxNext   = clrIdxQ;
    vecNext      = vecQ;
    vecValidNext = 1'b0;
    setRes       = '0;
    setIdx       = '0;

    if (ocw2_valid) begin
      unique case (ocw2_cmd)
        OCW2_NS_EOI, OCW2_ROT_NS_EOI: begin
          if (isrFound) begin
            isrNext[isrIdx] = 1'b0;
            clrValidNext    = 1'b1;
            clrIdxNext      = isrIdx;
            if (ROT_EN && (ocw2_cmd == OCW2_ROT_NS_EOI))
              lowNext = isrIdx;
          end
        end
        OCW2_SP_EOI, OCW2_ROT_SP_EOI: begin
          if (isrQ[ocw2_level]) begin
            isrNext[ocw2_level] = 1'b0;
            clrValidNext        = 1'b1;
            clrIdxNext          = ocw2_level;
            if (ROT_EN && (ocw2_cmd == OCW2_ROT_SP_EOI))
              lowNext = ocw2_level;
          end
        end
        OCW2_SET_PRIO: begin
          if (ROT_EN) lowNext = ocw2_level;
        end
        OCW2_ROT_AEOI_SET: begin
          if (ROT_EN) rotAeoiNext = 1'b1;
        end
        OCW2_ROT_AEOI_CLR: begin
          if (ROT_EN) rotAeoiNext = 1'b0;
        end
        OCW2_NOP: begin
        end
      endcase
    end

    // The set sees the post-EOI, post-rotation priority of this cycle.
    setRes = rotHighest(MAX_IRQ'(irq_req), MAX_IDX_W'(lowNext), NUM_IRQ);
    setIdx = IDX_W'(setRes.idx);

    if (inta_first) begin
      if (setRes.found) begin
        isrNext[setIdx] = 1'b1;
        servNext        = setIdx;
        armedNext       = 1'b1;
        spurNext        = 1'b0;
      end else begin
        servNext  = lowNext;
        armedNext = 1'b0;
        spurNext  = 1'b1;
      end
    end else if (inta_second) begin
      vecValidNext = 1'b1;
      vecNext      = {vector_base[7:IDX_W], servQ};
      armedNext    = 1'b0;
      if (aeoi_en && armedQ && isrNext[servQ]) begin
        isrNext[servQ] = 1'b0;
        clrValidNext   = 1'b1;
        clrIdxNext     = servQ;
        if (ROT_EN && rotAeoiQ) lowNext = servQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      isrQ      <= '0;
      lowQ      <= LOW_RST;
      servQ     <= LOW_RST;
      clrIdxQ   <= '0;
      clrValidQ <= 1'b0;
      rotAeoiQ  <= 1'b0;
      armedQ    <= 1'b0;
      spurQ     <= 1'b0;
      vecQ      <= '0;
      vecValidQ <= 1'b0;
      intQ      <= 1'b0;
    end else begin
      isrQ      <= isrNext;
      lowQ      <= lowNext;
      servQ     <= servNext;
      clrIdxQ   <= clrIdxNext;
      clrValidQ <= clrValidNext;
      rotAeoiQ  <= rotAeoiNext;
      armedQ    <= armedNext;
      spurQ     <= spurNext;
      vecQ      <= vecNext;
      vecValidQ <= vecValidNext;
      intQ      <= intNext;
    end
  end

  assign isr_value     = isrQ;
  assign int_out       = intQ;
  assign vector_out    = vecQ;
  assign vector_valid  = vecValidQ;
  assign spurious      = spurQ;
  assign cleared_valid = clrValidQ;
  assign cleared_idx   = clrIdxQ;
  assign lowest_prio   = lowQ;

endmodule

// File: tb/tb_pic_isr_param.sv
// Directed bench for pic_isr_param: 8-level vector table plus a 16-level sequence.
// Expectations follow the build's PIC_ISR_ROTATION_EN setting.
module tb_pic_isr_param;

`ifdef PIC_ISR_ROTATION_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i1, i2, aeoi, ov, vv, sp, cv, intO;
  logic [7:0] irq, base, isr, vec;
  logic [2:0] cmd, lvl, ci, low;

  logic        rst16, i1_16, i2_16, aeoi16, ov16, vv16, sp16, cv16, int16;
  logic [15:0] irq16, isr16;
  logic [7:0]  base16, vec16;
  logic [2:0]  cmd16;
  logic [3:0]  lvl16, ci16, low16;

  int passCnt = 0;
  int total   = 0;

  pic_isr_param #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .reset(rst), .irq_req(irq),
    .inta_first(i1), .inta_second(i2),
    .vector_base(base), .aeoi_en(aeoi),
    .ocw2_valid(ov), .ocw2_cmd(cmd), .ocw2_level(lvl),
    .isr_value(isr), .int_out(intO),
    .vector_out(vec), .vector_valid(vv),
    .spurious(sp), .cleared_valid(cv),
    .cleared_idx(ci), .lowest_prio(low)
  );

  pic_isr_param #(.NUM_IRQ(16)) dut16 (
    .clk(clk), .reset(rst16), .irq_req(irq16),
    .inta_first(i1_16), .inta_second(i2_16),
    .vector_base(base16), .aeoi_en(aeoi16),
    .ocw2_valid(ov16), .ocw2_cmd(cmd16), .ocw2_level(lvl16),
    .isr_value(isr16), .int_out(int16),
    .vector_out(vec16), .vector_valid(vv16),
    .spurious(sp16), .cleared_valid(cv16),
    .cleared_idx(ci16), .lowest_prio(low16)
  );

  typedef struct {
    logic       rst;
    logic [7:0] irq;
    logic       i1, i2, aeoi, ov;
    logic [2:0] cmd, lvl;
    logic [7:0] eIsr;
    logic       eInt;
    logic [7:0] eVec;
    logic       eVv, eSp, eCv;
    logic [2:0] eCi, eLow;
  } row_t;

  localparam int NROWS = 34;
  row_t tbl[NROWS];

  function automatic row_t mk(
    int rs, int rq, int a1, int a2, int ae, int o, int cm, int lv,
    int eI, int eN, int eV, int eVv, int eS, int eC, int eCi, int eL
  );
    row_t r;
    r.rst  = rs[0];   r.irq  = rq[7:0];
    r.i1   = a1[0];   r.i2   = a2[0];
    r.aeoi = ae[0];   r.ov   = o[0];
    r.cmd  = cm[2:0]; r.lvl  = lv[2:0];
    r.eIsr = eI[7:0]; r.eInt = eN[0];
    r.eVec = eV[7:0]; r.eVv  = eVv[0];
    r.eSp  = eS[0];   r.eCv  = eC[0];
    r.eCi  = eCi[2:0]; r.eLow = eL[2:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got === want) passCnt++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lA, lB, iA, iB, c19;
    lA  = ROT ? 1 : 7;
    iA  = ROT ? 8'h0C : 8'h0A;
    iB  = ROT ? 8'h04 : 8'h02;
    c19 = ROT ? 2 : 1;
    lB  = ROT ? 5 : 7;
    //              rs irq  i1 i2 ae ov cm lv   isr int vec   vv sp cv ci low
    tbl[0]  = mk(1, 'h00, 0, 0, 0, 0, 0, 0, 'h00, 0, 'h00, 0, 0, 0, 0, 7);
    tbl[1]  = mk(0, 'h28, 0, 0, 0, 0, 0, 0, 'h00, 1, 'h00, 0, 0, 0, 0, 7);
    tbl[2]  = mk(0, 'h28, 1, 0, 0, 0, 0, 0, 'h08, 1, 'h00, 0, 0, 0, 0, 7);
    tbl[3]  = mk(0, 'h28, 0, 1, 0, 0, 0, 0, 'h08, 0, 'hEB, 1, 0, 0, 0, 7);
    tbl[4]  = mk(0, 'h28, 0, 0, 0, 0, 0, 0, 'h08, 0, 'hEB, 0, 0, 0, 0, 7);
    tbl[5]  = mk(0, 'h00, 0, 0, 0, 1, 1, 0, 'h00, 0, 'hEB, 0, 0, 1, 3, 7);
    tbl[6]  = mk(0, 'h10, 0, 0, 1, 0, 0, 0, 'h00, 1, 'hEB, 0, 0, 0, 3, 7);
    tbl[7]  = mk(0, 'h10, 1, 0, 1, 0, 0, 0, 'h10, 1, 'hEB, 0, 0, 0, 3, 7);
    tbl[8]  = mk(0, 'h00, 0, 1, 1, 0, 0, 0, 'h00, 0, 'hEC, 1, 0, 1, 4, 7);
    tbl[9]  = mk(0, 'h00, 0, 0, 0, 0, 0, 0, 'h00, 0, 'hEC, 0, 0, 0, 4, 7);
    tbl[10] = mk(0, 'h00, 1, 0, 0, 0, 0, 0, 'h00, 0, 'hEC, 0, 1, 0, 4, 7);
    tbl[11] = mk(0, 'h00, 0, 1, 0, 0, 0, 0, 'h00, 0, 'hEF, 1, 1, 0, 4, 7);
    tbl[12] = mk(0, 'h00, 0, 0, 0, 0, 0, 0, 'h00, 0, 'hEF, 0, 1, 0, 4, 7);
    tbl[13] = mk(0, 'h08, 1, 0, 0, 0, 0, 0, 'h08, 1, 'hEF, 0, 0, 0, 4, 7);
    tbl[14] = mk(0, 'h02, 1, 0, 0, 0, 0, 0, 'h0A, 1, 'hEF, 0, 0, 0, 4, 7);
    tbl[15] = mk(0, 'h00, 0, 0, 0, 1, 5, 0, 'h08, 0, 'hEF, 0, 0, 1, 1, lA);
    tbl[16] = mk(0, 'h06, 1, 0, 0, 0, 0, 0, iA, 1, 'hEF, 0, 0, 0, 1, lA);
    tbl[17] = mk(0, 'h00, 0, 0, 0, 1, 6, 7, iA, 0, 'hEF, 0, 0, 0, 1, 7);
    tbl[18] = mk(0, 'h00, 0, 0, 0, 1, 3, 3, iB, 0, 'hEF, 0, 0, 1, 3, 7);
    tbl[19] = mk(0, 'h00, 0, 0, 0, 1, 1, 0, 'h00, 0, 'hEF, 0, 0, 1, c19, 7);
    tbl[20] = mk(0, 'h00, 0, 0, 0, 1, 3, 5, 'h00, 0, 'hEF, 0, 0, 0, c19, 7);
    tbl[21] = mk(0, 'h08, 1, 0, 0, 0, 0, 0, 'h08, 1, 'hEF, 0, 0, 0, c19, 7);
    tbl[22] = mk(0, 'h08, 1, 0, 0, 1, 3, 3, 'h08, 0, 'hEF, 0, 0, 1, 3, 7);
    tbl[23] = mk(0, 'h00, 0, 0, 0, 1, 1, 0, 'h00, 0, 'hEF, 0, 0, 1, 3, 7);
    tbl[24] = mk(0, 'h01, 1, 1, 0, 0, 0, 0, 'h01, 1, 'hEF, 0, 0, 0, 3, 7);
    tbl[25] = mk(0, 'h00, 0, 1, 0, 0, 0, 0, 'h01, 0, 'hE8, 1, 0, 0, 3, 7);
    tbl[26] = mk(0, 'h04, 1, 0, 0, 0, 0, 0, 'h05, 0, 'hE8, 0, 0, 0, 3, 7);
    tbl[27] = mk(1, 'h00, 0, 0, 0, 0, 0, 0, 'h00, 0, 'h00, 0, 0, 0, 0, 7);
    tbl[28] = mk(0, 'h00, 0, 1, 1, 0, 0, 0, 'h00, 0, 'hEF, 1, 0, 0, 0, 7);
    tbl[29] = mk(0, 'h00, 0, 0, 0, 1, 4, 0, 'h00, 0, 'hEF, 0, 0, 0, 0, 7);
    tbl[30] = mk(0, 'h20, 1, 0, 1, 0, 0, 0, 'h20, 1, 'hEF, 0, 0, 0, 0, 7);
    tbl[31] = mk(0, 'h00, 0, 1, 1, 0, 0, 0, 'h00, 0, 'hED, 1, 0, 1, 5, lB);
    tbl[32] = mk(0, 'h00, 0, 0, 0, 1, 6, 7, 'h00, 0, 'hED, 0, 0, 0, 5, 7);
    tbl[33] = mk(0, 'h00, 0, 0, 0, 1, 0, 0, 'h00, 0, 'hED, 0, 0, 0, 5, 7);

    rst = 1'b1; irq = '0; i1 = 0; i2 = 0; aeoi = 0; ov = 0;
    cmd = '0; lvl = '0; base = 8'hE8;
    rst16 = 1'b1; irq16 = '0; i1_16 = 0; i2_16 = 0; aeoi16 = 0;
    ov16 = 0; cmd16 = '0; lvl16 = '0; base16 = 8'h40;

    for (int i = 0; i < NROWS; i++) begin
      rst  = tbl[i].rst;  irq = tbl[i].irq;
      i1   = tbl[i].i1;   i2  = tbl[i].i2;
      aeoi = tbl[i].aeoi; ov  = tbl[i].ov;
      cmd  = tbl[i].cmd;  lvl = tbl[i].lvl;
      step();
      check($sformatf("row%0d isr/int/vec/vv/sp/cv/ci/low", i),
            32'({isr, intO, vec, vv, sp, cv, ci, low}),
            32'({tbl[i].eIsr, tbl[i].eInt, tbl[i].eVec, tbl[i].eVv,
                 tbl[i].eSp, tbl[i].eCv, tbl[i].eCi, tbl[i].eLow}));
    end
    rst = 1'b0; irq = '0; i1 = 0; i2 = 0; aeoi = 0; ov = 0;

    rst16 = 1'b0;
    ov16 = 1'b1; cmd16 = 3'b110; lvl16 = 4'd5;
    step();
    ov16 = 1'b0;
    check("n16 setprio low", 32'(low16), ROT ? 32'd5 : 32'd15);
    irq16 = 16'h8040;
    step();
    check("n16 int raised", 32'(int16), 32'd1);
    i1_16 = 1'b1;
    step();
    i1_16 = 1'b0;
    check("n16 first isr", 32'(isr16), 32'h0040);
    i2_16 = 1'b1;
    step();
    i2_16 = 1'b0;
    check("n16 first vec", 32'({vv16, vec16}), 32'h146);
    check("n16 int low", 32'(int16), 32'd0);
    irq16 = 16'h8000; ov16 = 1'b1; cmd16 = 3'b001;
    step();
    ov16 = 1'b0;
    check("n16 eoi", 32'({cv16, ci16, isr16}), 32'({1'b1, 4'd6, 16'h0}));
    i1_16 = 1'b1;
    step();
    i1_16 = 1'b0;
    check("n16 second isr", 32'(isr16), 32'h8000);
    i2_16 = 1'b1;
    step();
    i2_16 = 1'b0;
    check("n16 second vec", 32'({vv16, vec16}), 32'h14F);

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule

// File: doc/pic_isr_param.md
# pic_isr_param

Parametrised In-Service Register (ISR) for the 8259A-style PIC. It tracks serviced interrupt levels across an INTA handshake and emits the interrupt vector. It executes OCW2 EOI, rotate and set-priority commands, and raises INT when a pending request outranks everything in service. It sits between the IRR/IMR masking stage and the control-logic/data-bus buffer, and replaces the fixed 8-level ISR.

## Interface
- NUM_IRQ, 8, number of interrupt levels; legal values 2, 4, 8, 16, 32.
- IDX_W, $clog2(NUM_IRQ), level index width (derived, not overridden).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irq_req  in  NUM_IRQ  masked pending requests from the IRR/IMR stage.
- inta_first  in  1  one-cycle pulse, first INTA.
- inta_second  in  1  one-cycle pulse, second INTA.
- vector_base  in  8  ICW2 value; bits [7:IDX_W] form the vector high part.
- aeoi_en  in  1  ICW4 AEOI bit.
- ocw2_valid  in  1  one-cycle pulse, new OCW2 written.
- ocw2_cmd  in  3  OCW2 {R, SL, EOI}.
- ocw2_level  in  IDX_W  OCW2 level field.
- isr_value  out  NUM_IRQ  current ISR contents.
- int_out  out  1  interrupt request to the CPU.
- vector_out  out  8  vector byte.
- vector_valid  out  1  vector_out valid, one cycle.
- spurious  out  1  last inta_first found no request.
- cleared_valid  out  1  one-cycle pulse, an ISR bit was cleared.
- cleared_idx  out  IDX_W  index of the bit cleared.
- lowest_prio  out  IDX_W  current lowest-priority level.

## Operation
- Priority order is lowest_prio+1 (highest) through lowest_prio (lowest), taken modulo NUM_IRQ.
- int_out is 1 when the highest-ranked bit of irq_req outranks the highest-ranked bit of isr_value, or when isr_value == 0 and irq_req != 0.
- **inta_first:**
  - Sets the ISR bit of the highest-ranked irq_req and latches its index as serv_idx.
  - If irq_req == 0, no ISR bit is set, serv_idx = lowest_prio and spurious = 1.
- **inta_second:** vector_out = {vector_base[7:IDX_W], serv_idx}.
- **AEOI:** when aeoi_en = 1, the serv_idx bit clears on inta_second. If rotate-in-AEOI is set, lowest_prio = serv_idx.
- **OCW2 commands** on ocw2_valid:
  - 001 non-specific EOI: clear the highest-ranked ISR bit.
  - 011 specific EOI: clear bit ocw2_level.
  - 101 rotate on non-specific EOI: do the 001 clear, then lowest_prio = cleared index.
  - 111 rotate on specific EOI: clear bit ocw2_level, lowest_prio = ocw2_level.
  - 110 set priority: lowest_prio = ocw2_level.
  - 100 set rotate-in-AEOI flag; 000 clear it; 010 no operation.
- Any EOI whose target bit is already 0 is a no-op: no cleared_valid, and no rotation.

## Timing
- **Reset values:** isr_value = 0, int_out = 0, vector_out = 0, vector_valid = 0, spurious = 0, cleared_valid = 0, cleared_idx = 0, lowest_prio = NUM_IRQ-1, rotate-in-AEOI flag = 0.
- **Registered updates:** all state changes occur at the clk edge that samples the strobe.
  - isr_value updates the cycle after inta_first.
  - vector_out/vector_valid are valid the cycle after inta_second.
- **cleared_valid/cleared_idx:** pulse in the cycle after the clearing edge.
- **int_out:** registered; reflects the irq_req/isr_value state of the previous cycle.
- **OCW2 and inta_first in the same cycle:** the EOI clear is applied first; the set then uses the post-rotation priority.
- **inta_second without a preceding inta_first:** vector uses the last serv_idx (reset value NUM_IRQ-1) and no AEOI clear occurs.
- **Invalid pairing:** inta_first and inta_second are never asserted together. If they are, inta_first has priority and inta_second is ignored.
- **Reset mid-handshake:** the handshake is abandoned. All outputs return to their reset values and serv_idx = NUM_IRQ-1.

## Configuration
- PIC_ISR_ROTATION_EN:
  - **Defined:** rotation is supported (commands 101, 111, 110, 100/000 as above).
  - **Undefined:** lowest_prio is fixed at NUM_IRQ-1. Command 101 behaves as 001, 111 as 011, and 110/100/000 are no-ops.

## Structure
- Package pic_isr_pkg holds:
  - localparams for the OCW2 command encodings;
  - the max NUM_IRQ constant;
  - a function that computes the rotated highest-ranked index.
- Sub-module pic_rot_priority_resolver, instantiated twice (irq_req and isr_value).
  - Inputs: vector and lowest_prio.
  - Outputs: found flag and index of the highest-ranked set bit.

## Test plan
- NUM_IRQ=8, irq_req=0x28, inta_first, inta_second, vector_base=0xE8 -> isr_value=0x08, vector_out=0xEB, int_out falls.
- aeoi_en=1, irq_req=0x10, full handshake -> isr_value returns to 0; cleared_valid with cleared_idx=4.
- irq_req=0, inta_first, inta_second, vector_base=0xE8 -> spurious=1, isr_value=0, vector_out=0xEF.
- isr_value=0x0A, OCW2 101 -> bit1 clears, lowest_prio=1. Then irq_req=0x06 -> inta_first services level 2.
- NUM_IRQ=16, OCW2 110 level 5, irq_req=0x8040 -> level 6 serviced first, then level 15.
- OCW2 011 level 3 and inta_first with irq_req=0x08 in the same cycle, with isr_value=0x08 -> bit3 cleared then re-set, cleared_valid pulses.
